// File: rtl/axi4_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_sw_pkg
// Brief    : Shared AXI4-Stream switch types and default field widths.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_sw_pkg;

    localparam int DEF_TDATA_L = 512;
    localparam int DEF_TUSER_L = 81;
    localparam int DEF_TKEEP_L = 16;

    typedef struct packed {
        logic [DEF_TDATA_L-1:0] tdata;
        logic [DEF_TUSER_L-1:0] tuser;
        logic [DEF_TKEEP_L-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

    localparam int DEF_BEAT_W = $bits(axis_beat_t);

    typedef enum logic [0:0] {
        STORE = 1'b0,
        CUT   = 1'b1
    } egress_mode_e;

    // Flattened width of one stored beat for arbitrary field widths.
    function automatic int beat_width(input int dl, input int ul, input int kl);
        return dl + ul + kl + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_pkt_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi4_pkt_fifo_ram
// Brief    : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_pkt_fifo_ram
    import axi4_sw_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = DEF_BEAT_W
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/axi4_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi4_pkt_fifo
// Brief    : Store-and-forward AXI4-Stream packet FIFO with oversize cut-through.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_pkt_fifo
    import axi4_sw_pkg::*;
#(
    parameter int TDATA_L = DEF_TDATA_L,
    parameter int TUSER_L = DEF_TUSER_L,
    parameter int TKEEP_L = DEF_TKEEP_L,
    parameter int DEPTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TDATA_L-1:0]     axi_s_tdata_i,
    input  logic [TUSER_L-1:0]     axi_s_tuser_i,
    input  logic [TKEEP_L-1:0]     axi_s_tkeep_i,
    input  logic                   axi_s_tlast_i,
    input  logic                   axi_s_tvalid_i,
    output logic                   axi_s_tready_o,
    output logic [TDATA_L-1:0]     axi_m_tdata_o,
    output logic [TUSER_L-1:0]     axi_m_tuser_o,
    output logic [TKEEP_L-1:0]     axi_m_tkeep_o,
    output logic                   axi_m_tlast_o,
    output logic                   axi_m_tvalid_o,
    input  logic                   axi_m_tready_i,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [$clog2(DEPTH):0] pkt_cnt_o,
    output logic                   oversize_o
);

    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam int              BEAT_W   = beat_width(TDATA_L, TUSER_L, TKEEP_L);
    localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);
    localparam logic [0:0]      S_STORE  = 1'(STORE);
    localparam logic [0:0]      S_CUT    = 1'(CUT);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] occ_q, occ_d;
    logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic [0:0]      state_q, state_d;
    logic            oversize_q, oversize_d;

    logic              full, empty;
    logic              wr_en, rd_en, wr_last, rd_last;
    logic [BEAT_W-1:0] wr_beat, rd_beat;

    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Ready depends only on registered pointers, so a read at full frees space next cycle.
    assign axi_s_tready_o = !full;
    assign axi_m_tvalid_o = (state_q == S_CUT) ? !empty : (pkt_cnt_q != '0);

    assign wr_en   = axi_s_tvalid_i && !full;
    assign rd_en   = axi_m_tvalid_o && axi_m_tready_i;
    assign wr_last = wr_en && axi_s_tlast_i;
    assign rd_last = rd_en && axi_m_tlast_o;

    assign wr_beat = {axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i, axi_s_tlast_i};
    assign {axi_m_tdata_o, axi_m_tuser_o, axi_m_tkeep_o, axi_m_tlast_o} = rd_beat;

    axi4_pkt_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_beat),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_beat)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        state_d    = state_q;
        oversize_d = oversize_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (wr_en && !rd_en) begin
            occ_d = occ_q + 1'b1;
        end else if (!wr_en && rd_en) begin
            occ_d = occ_q - 1'b1;
        end

        if (wr_last && !rd_last) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (!wr_last && rd_last) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end

        // Entry uses next-state values so egress valid rises right after the filling write.
        case (state_q)
            S_STORE: begin
                if ((occ_d == FULL_OCC) && (pkt_cnt_d == '0)) begin
                    state_d    = S_CUT;
                    oversize_d = 1'b1;
                end
            end
            S_CUT: begin
                if (rd_last) begin
                    state_d = S_STORE;
                end
            end
            default: state_d = S_STORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            state_q    <= S_STORE;
            oversize_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
            state_q    <= state_d;
            oversize_q <= oversize_d;
        end
    end

    assign occupancy_o = occ_q;
    assign pkt_cnt_o   = pkt_cnt_q;
    assign oversize_o  = oversize_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_pkt_fifo
// Brief    : Self-checking bench for axi4_pkt_fifo against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_pkt_fifo;
    import axi4_sw_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [511:0]  s_data;
    logic [80:0]   s_user;
    logic [15:0]   s_keep;
    logic          s_last;
    logic          s_valid;
    logic          s_ready;
    logic [511:0]  m_data;
    logic [80:0]   m_user;
    logic [15:0]   m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   occ;
    logic [AW:0]   pkt;
    logic          over;

    int checks   = 0;
    int failures = 0;

    // Reference model: beat queue, completed-packet count, cut-through mode, sticky flag
    axis_beat_t q[$];
    int         m_pkts = 0;
    bit         m_cut  = 0;
    bit         m_over = 0;

    always #5 clk = ~clk;

    axi4_pkt_fifo #(
        .TDATA_L (512),
        .TUSER_L (81),
        .TKEEP_L (16),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi_s_tdata_i  (s_data),
        .axi_s_tuser_i  (s_user),
        .axi_s_tkeep_i  (s_keep),
        .axi_s_tlast_i  (s_last),
        .axi_s_tvalid_i (s_valid),
        .axi_s_tready_o (s_ready),
        .axi_m_tdata_o  (m_data),
        .axi_m_tuser_o  (m_user),
        .axi_m_tkeep_o  (m_keep),
        .axi_m_tlast_o  (m_last),
        .axi_m_tvalid_o (m_valid),
        .axi_m_tready_i (m_ready),
        .occupancy_o    (occ),
        .pkt_cnt_o      (pkt),
        .oversize_o     (over)
    );

    function automatic bit exp_sready();
        return q.size() < DEPTH;
    endfunction

    function automatic bit exp_mvalid();
        return m_cut ? (q.size() != 0) : (m_pkts != 0);
    endfunction

    task automatic drive(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = 512'(d);
        s_user  = 81'({$urandom(), $urandom(), $urandom()});
        s_keep  = 16'($urandom());
        s_last  = last;
    endtask

    // Advances one clock (from negedge to next negedge) and applies the transfers to the model.
    task automatic clk_step(output bit wr, output bit rd);
        axis_beat_t inb, front;
        wr = s_valid && exp_sready();
        rd = exp_mvalid() && m_ready;
        inb.tdata = s_data;
        inb.tuser = s_user;
        inb.tkeep = s_keep;
        inb.tlast = s_last;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_pkts = 0;
            m_cut  = 0;
            m_over = 0;
            wr     = 0;
            rd     = 0;
        end else begin
            if (rd) begin
                front = q.pop_front();
                if (front.tlast) begin
                    m_pkts--;
                    m_cut = 0;
                end
            end
            if (wr) begin
                q.push_back(inb);
                if (inb.tlast) m_pkts++;
            end
            if (!m_cut && q.size() == DEPTH && m_pkts == 0) begin
                m_cut  = 1;
                m_over = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit wr, rd;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        s_data = '0; s_user = '0; s_keep = '0;
        @(negedge clk);
        clk_step(wr, rd);
        clk_step(wr, rd);
        rst_n = 1'b1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_sready got=%0b want=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%0b want=0", m_valid); end
        checks++; if (occ !== '0) begin failures++; $display("FAIL reset_occ got=%0d want=0", occ); end
        checks++; if (pkt !== '0) begin failures++; $display("FAIL reset_pkt got=%0d want=0", pkt); end
        checks++; if (over !== 1'b0) begin failures++; $display("FAIL reset_over got=%0b want=0", over); end
    endtask

    task automatic test_single_beat();
        bit wr, rd;
        m_ready = 1'b1;
        drive(32'hA0A0_0014, 1'b1);
        clk_step(wr, rd);
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_mvalid got=%0b want=1", m_valid); end
        checks++; if (m_data[31:0] !== 32'hA0A0_0014) begin failures++; $display("FAIL single_data got=%0h want=a0a00014", m_data[31:0]); end
        checks++; if (occ !== 1) begin failures++; $display("FAIL single_occ1 got=%0d want=1", occ); end
        checks++; if (pkt !== 1) begin failures++; $display("FAIL single_pkt1 got=%0d want=1", pkt); end
        clk_step(wr, rd);
        checks++; if (occ !== 0) begin failures++; $display("FAIL single_occ0 got=%0d want=0", occ); end
        checks++; if (pkt !== 0) begin failures++; $display("FAIL single_pkt0 got=%0d want=0", pkt); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_mvalid0 got=%0b want=0", m_valid); end
    endtask

    task automatic test_three_beat();
        bit wr, rd;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hB0B0_0019 + i, i == 2);
            clk_step(wr, rd);
            s_valid = 1'b0;
            if (i < 2) begin
                checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL three_early_valid beat=%0d got=%0b want=0", i, m_valid); end
                clk_step(wr, rd);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL three_valid beat=%0d got=%0b want=1", i, m_valid); end
            checks++; if (m_data[31:0] !== 32'hB0B0_0019 + i) begin failures++; $display("FAIL three_data beat=%0d got=%0h want=%0h", i, m_data[31:0], 32'hB0B0_0019 + i); end
            checks++; if (m_last !== (i == 2)) begin failures++; $display("FAIL three_last beat=%0d got=%0b want=%0b", i, m_last, i == 2); end
            clk_step(wr, rd);
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL three_done_valid got=%0b want=0", m_valid); end
    endtask

    task automatic test_hold_four();
        bit wr, rd;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'hC000_0000 + i, 1'b1);
            clk_step(wr, rd);
        end
        s_valid = 1'b0;
        checks++; if (pkt !== 4) begin failures++; $display("FAIL hold_pkt got=%0d want=4", pkt); end
        checks++; if (occ !== 4) begin failures++; $display("FAIL hold_occ got=%0d want=4", occ); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data[31:0] !== 32'hC000_0000 + i) begin
                failures++; $display("FAIL hold_out beat=%0d got=%0h/%0b want=%0h/1", i, m_data[31:0], m_valid, 32'hC000_0000 + i);
            end
            clk_step(wr, rd);
        end
        checks++; if (pkt !== 0 || occ !== 0) begin failures++; $display("FAIL hold_drain got=%0d/%0d want=0/0", pkt, occ); end
    endtask

    task automatic test_oversize();
        bit wr, rd;
        int sent, rcv, cyc;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(32'hD000_0000 + i, 1'b0);
            clk_step(wr, rd);
        end
        sent = DEPTH;
        drive(32'hD000_0000 + DEPTH, 1'b0);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL over_sready got=%0b want=0", s_ready); end
        checks++; if (over !== 1'b1) begin failures++; $display("FAIL over_flag got=%0b want=1", over); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL over_mvalid got=%0b want=1", m_valid); end
        checks++; if (occ !== DEPTH) begin failures++; $display("FAIL over_occ got=%0d want=%0d", occ, DEPTH); end
        m_ready = 1'b1;
        rcv = 0;
        cyc = 0;
        while (rcv < DEPTH + 2 && cyc < 8 * DEPTH) begin
            if (sent < DEPTH + 2) drive(32'hD000_0000 + sent, sent == DEPTH + 1);
            else s_valid = 1'b0;
            checks++; if (s_ready !== exp_sready()) begin failures++; $display("FAIL over_drain_sready cyc=%0d got=%0b want=%0b", cyc, s_ready, exp_sready()); end
            checks++; if (m_valid !== exp_mvalid()) begin failures++; $display("FAIL over_drain_mvalid cyc=%0d got=%0b want=%0b", cyc, m_valid, exp_mvalid()); end
            if (exp_mvalid()) begin
                checks++; if (m_data[31:0] !== 32'hD000_0000 + rcv || m_last !== (rcv == DEPTH + 1)) begin
                    failures++; $display("FAIL over_drain_data idx=%0d got=%0h/%0b want=%0h/%0b", rcv, m_data[31:0], m_last, 32'hD000_0000 + rcv, rcv == DEPTH + 1);
                end
            end
            clk_step(wr, rd);
            if (wr) sent++;
            if (rd) rcv++;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (rcv !== DEPTH + 2) begin failures++; $display("FAIL over_drain_count got=%0d want=%0d", rcv, DEPTH + 2); end
        checks++; if (over !== 1'b1) begin failures++; $display("FAIL over_sticky got=%0b want=1", over); end
        drive(32'hE000_0000, 1'b0);
        clk_step(wr, rd);
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b0 || occ !== 1) begin failures++; $display("FAIL over_store_again got=%0b/%0d want=0/1", m_valid, occ); end
    endtask

    task automatic test_reset_mid();
        bit wr, rd;
        m_ready = 1'b0;
        drive(32'hF000_0001, 1'b0);
        clk_step(wr, rd);
        drive(32'hF000_0002, 1'b0);
        clk_step(wr, rd);
        s_valid = 1'b0;
        rst_n = 1'b0;
        clk_step(wr, rd);
        rst_n = 1'b1;
        checks++; if (occ !== 0) begin failures++; $display("FAIL rstmid_occ got=%0d want=0", occ); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_mvalid got=%0b want=0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_sready got=%0b want=1", s_ready); end
        checks++; if (over !== 1'b0) begin failures++; $display("FAIL rstmid_over got=%0b want=0", over); end
        drive(32'hF000_0011, 1'b0);
        clk_step(wr, rd);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_partial_valid got=%0b want=0", m_valid); end
        drive(32'hF000_0012, 1'b1);
        clk_step(wr, rd);
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data[31:0] !== 32'hF000_0011) begin failures++; $display("FAIL rstmid_fresh got=%0b/%0h want=1/f0000011", m_valid, m_data[31:0]); end
        checks++; if (pkt !== 1 || occ !== 2) begin failures++; $display("FAIL rstmid_counts got=%0d/%0d want=1/2", pkt, occ); end
        m_ready = 1'b1;
        clk_step(wr, rd);
        clk_step(wr, rd);
        checks++; if (occ !== 0) begin failures++; $display("FAIL rstmid_drain got=%0d want=0", occ); end
    endtask

    task automatic test_simul_tlast();
        bit wr, rd;
        m_ready = 1'b0;
        drive(32'hE100_0001, 1'b1);
        clk_step(wr, rd);
        checks++; if (pkt !== 1 || occ !== 1) begin failures++; $display("FAIL simul_pre got=%0d/%0d want=1/1", pkt, occ); end
        m_ready = 1'b1;
        drive(32'hE100_0002, 1'b1);
        clk_step(wr, rd);
        s_valid = 1'b0;
        checks++; if (pkt !== 1) begin failures++; $display("FAIL simul_pkt got=%0d want=1", pkt); end
        checks++; if (occ !== 1) begin failures++; $display("FAIL simul_occ got=%0d want=1", occ); end
        checks++; if (m_data[31:0] !== 32'hE100_0002) begin failures++; $display("FAIL simul_data got=%0h want=e1000002", m_data[31:0]); end
        clk_step(wr, rd);
        checks++; if (pkt !== 0 || occ !== 0) begin failures++; $display("FAIL simul_drain got=%0d/%0d want=0/0", pkt, occ); end
    endtask

    // Random traffic; alternating phases of short packets and long packets under heavy backpressure.
    task automatic test_random();
        bit wr, rd, longp;
        axis_beat_t f;
        wr = 1'b1;
        s_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            longp = ((c / 600) % 2) == 1;
            if (wr || !s_valid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 16; k++) s_data[k*32 +: 32] = $urandom();
                s_user = 81'({$urandom(), $urandom(), $urandom()});
                s_keep = 16'($urandom());
                s_last = longp ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0);
            end
            m_ready = longp ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
            checks++; if (s_ready !== exp_sready()) begin failures++; $display("FAIL rnd_sready c=%0d got=%0b want=%0b", c, s_ready, exp_sready()); end
            checks++; if (m_valid !== exp_mvalid()) begin failures++; $display("FAIL rnd_mvalid c=%0d got=%0b want=%0b", c, m_valid, exp_mvalid()); end
            checks++; if (occ !== q.size()) begin failures++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, occ, q.size()); end
            checks++; if (pkt !== m_pkts) begin failures++; $display("FAIL rnd_pkt c=%0d got=%0d want=%0d", c, pkt, m_pkts); end
            checks++; if (over !== m_over) begin failures++; $display("FAIL rnd_over c=%0d got=%0b want=%0b", c, over, m_over); end
            if (exp_mvalid()) begin
                f = q[0];
                checks++; if (m_data !== f.tdata || m_user !== f.tuser || m_keep !== f.tkeep || m_last !== f.tlast) begin
                    failures++; $display("FAIL rnd_beat c=%0d got=%0h/%0b want=%0h/%0b", c, m_data[63:0], m_last, f.tdata[63:0], f.tlast);
                end
            end
            clk_step(wr, rd);
        end
        s_valid = 1'b0;
        checks++; if (m_over !== 1'b1 || over !== 1'b1) begin failures++; $display("FAIL rnd_cut_seen got=%0b want=1", over); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_three_beat();
        test_hold_four();
        test_oversize();
        test_reset_mid();
        test_simul_tlast();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
